// File: rtl/rns_alu_sched.sv
// rns_alu_sched: EX-stage RNS ALU sequencer.
// Accepts one packed multi-domain operation. By default a single shared
// 8-bit modular lane is time-multiplexed across the domains, one per cycle.
// It holds the packed result until the consumer accepts it.
// Optional build macro: RNS_SCHED_PARALLEL_EN instantiates one lane per
// domain, so every domain is computed in a single RUN cycle.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1 outside reset)
// RUN   | computing residue slices (serial: one domain per edge)
// DONE  | result valid and held until res_ready
module rns_alu_sched #(
  parameter int                       NUM_DOMAINS = 1,
  parameter logic [NUM_DOMAINS*8-1:0] MODULI      = {NUM_DOMAINS{8'd255}},
  localparam int                      IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_DOMAINS*8-1:0] op1,
  input  logic [NUM_DOMAINS*8-1:0] op2,
  input  logic [2:0]               op_sel,
  input  logic                     flush,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NUM_DOMAINS*8-1:0] result,
  output logic                     zero_eq_flag,
  output logic                     busy,
  output logic [IDX_W-1:0]         cur_domain
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_DOMAINS*8-1:0] op1_q, op1_d;
  logic [NUM_DOMAINS*8-1:0] op2_q, op2_d;
  logic [2:0]               op_sel_q, op_sel_d;
  logic [NUM_DOMAINS*8-1:0] result_q, result_d;
  logic                     flag_q, flag_d;
  logic [NUM_DOMAINS*8-1:0] run_result;
  logic                     run_last;

  // One modular lane. The 9-bit intermediate keeps the carry so that
  // sums up to 2*255 reduce correctly; bitwise ops are never reduced.
  function automatic logic [7:0] lane_op(input logic [2:0] sel,
                                         input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] m);
    logic [8:0] s;
    logic [7:0] addend;
    logic [7:0] r;
    s      = '0;
    r      = '0;
    addend = (sel == OP_SHL) ? a : b;
    case (sel)
      OP_ADD, OP_SHL: begin
        s = {1'b0, a} + {1'b0, addend};
        r = (s >= {1'b0, m}) ? 8'(s - {1'b0, m}) : s[7:0];
      end
      OP_SUB: begin
        if (a >= b) begin
          r = a - b;
        end else begin
          s = {1'b0, a} + {1'b0, m} - {1'b0, b};
          r = s[7:0];
        end
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      OP_CMP:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Flag combines every slice of the final result, or compares all domains for CMP.
  function automatic logic final_flag(input logic [2:0] sel,
                                      input logic [NUM_DOMAINS*8-1:0] a,
                                      input logic [NUM_DOMAINS*8-1:0] b,
                                      input logic [NUM_DOMAINS*8-1:0] res);
    return (sel == OP_CMP) ? (a == b) : (res == '0);
  endfunction

`ifdef RNS_SCHED_PARALLEL_EN

  // All domains are evaluated at once; one lane per domain.
  always_comb begin
    run_result = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      run_result[(NUM_DOMAINS-i)*8-1 -: 8] = lane_op(op_sel_q,
                                                     op1_q[(NUM_DOMAINS-i)*8-1 -: 8],
                                                     op2_q[(NUM_DOMAINS-i)*8-1 -: 8],
                                                     MODULI[(NUM_DOMAINS-i)*8-1 -: 8]);
    end
    run_last = 1'b1;
  end

  assign cur_domain = '0;

`else

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       lane_a, lane_b, lane_m, lane_r;

  // Shared lane: mux in the slices of domain idx and merge its result into the held result.
  always_comb begin
    lane_a     = '0;
    lane_b     = '0;
    lane_m     = '0;
    run_result = result_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lane_a = op1_q[(NUM_DOMAINS-i)*8-1 -: 8];
        lane_b = op2_q[(NUM_DOMAINS-i)*8-1 -: 8];
        lane_m = MODULI[(NUM_DOMAINS-i)*8-1 -: 8];
      end
    end
    lane_r = lane_op(op_sel_q, lane_a, lane_b, lane_m);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        run_result[(NUM_DOMAINS-i)*8-1 -: 8] = lane_r;
      end
    end
    run_last = (idx_q == LAST_IDX);
  end

  // Domain index: restarts on accept, advances each RUN edge, parks at 0 elsewhere.
  always_comb begin
    idx_d = '0;
    if (state_q == RUN && !flush && !run_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Domain index register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_d_apply: idx_q <= idx_d;
    end
  end

  assign cur_domain = (state_q == RUN) ? idx_q : '0;

`endif

  // Next-state and datapath update; flush outranks every other transition.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op_sel_d = op_sel_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          op1_d    = op1;
          op2_d    = op2;
          op_sel_d = op_sel;
          result_d = '0;
          flag_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          result_d = '0;
          flag_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          result_d = run_result;
          if (run_last) begin
            flag_d  = final_flag(op_sel_q, op1_q, op2_q, run_result);
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush) begin
          result_d = '0;
          flag_d   = 1'b0;
          state_d  = IDLE;
        end else if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        result_d = '0;
        flag_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, operand latches and result register; reset aborts any operation at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      op_sel_q <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op_sel_q <= op_sel_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // req_ready is gated by reset so it reads 0 for the whole reset interval.
  assign req_ready    = reset && (state_q == IDLE);
  assign res_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign zero_eq_flag = flag_q;

endmodule

// File: tb/tb_rns_alu_sched.sv
// Directed bench for rns_alu_sched with three domains, moduli {7,11,13}.
module tb_rns_alu_sched;

  localparam int ND = 3;
  localparam logic [ND*8-1:0] MODS = {8'd7, 8'd11, 8'd13};
`ifdef RNS_SCHED_PARALLEL_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = ND;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [ND*8-1:0] op1 = '0;
  logic [ND*8-1:0] op2 = '0;
  logic [2:0]    op_sel = '0;
  logic          flush = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [ND*8-1:0] result;
  logic          zero_eq_flag;
  logic          busy;
  logic [1:0]    cur_domain;

  int checks = 0;
  int failures = 0;
  int cd_log [0:7];

  rns_alu_sched #(.NUM_DOMAINS(ND), .MODULI(MODS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op1(op1), .op2(op2), .op_sel(op_sel), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .zero_eq_flag(zero_eq_flag), .busy(busy), .cur_domain(cur_domain)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait (bounded) for res_valid; result stays in DONE.
  task automatic run_op(input string tag, input logic [ND*8-1:0] a, input logic [ND*8-1:0] b,
                        input logic [2:0] sel, input logic [ND*8-1:0] exp_res, input logic exp_flag);
    int edges;
    op1 = a; op2 = b; op_sel = sel; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    op1 = '1; op2 = '1; op_sel = 3'b010;
    edges = 0;
    while (!res_valid && edges < 20) begin
      cd_log[edges] = int'(cur_domain);
      tick();
      edges++;
    end
    chk({tag, "_latency"}, edges, EXP_LAT);
    chk({tag, "_result"}, {8'h0, result}, {8'h0, exp_res});
    chk({tag, "_flag"}, zero_eq_flag, exp_flag);
  endtask

  task automatic accept_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 1'b0);
    chk({tag, "_ready_back"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [ND*8-1:0] held;
    int seen_valid;

    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_flag", zero_eq_flag, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);
    tick();

    // Test 1: ADD with latency and domain sequencing
    run_op("add", {8'd5, 8'd9, 8'd12}, {8'd4, 8'd5, 8'd3}, 3'b000, {8'd2, 8'd3, 8'd2}, 1'b0);
`ifndef RNS_SCHED_PARALLEL_EN
    chk("add_cd0", cd_log[0], 0);
    chk("add_cd1", cd_log[1], 1);
    chk("add_cd2", cd_log[2], 2);
`endif
    // Test 4: backpressure in DONE
    held = result;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result", result, held);
      chk("bp_flag", zero_eq_flag, 1'b0);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
      chk("bp_valid", res_valid, 1'b1);
    end
    accept_result("add");
    chk("idle_busy", busy, 1'b0);

    // Test 2: SUB and SHL
    run_op("sub", {8'd2, 8'd3, 8'd1}, {8'd5, 8'd9, 8'd12}, 3'b001, {8'd4, 8'd5, 8'd2}, 1'b0);
    accept_result("sub");
    run_op("shl", {8'd6, 8'd10, 8'd12}, {8'd0, 8'd0, 8'd0}, 3'b101, {8'd5, 8'd9, 8'd11}, 1'b0);
    accept_result("shl");

    // Test 3: CMP equal and unequal
    run_op("cmp_eq", {8'd3, 8'd4, 8'd5}, {8'd3, 8'd4, 8'd5}, 3'b111, {8'd3, 8'd4, 8'd5}, 1'b1);
    accept_result("cmp_eq");
    run_op("cmp_ne", {8'd3, 8'd4, 8'd5}, {8'd3, 8'd4, 8'd6}, 3'b111, {8'd3, 8'd4, 8'd5}, 1'b0);
    accept_result("cmp_ne");

    // Bitwise ops are unreduced; PASS of zero raises the zero flag
    run_op("and", {8'hF0, 8'h0F, 8'hAA}, {8'h3C, 8'h3C, 8'h0F}, 3'b010, {8'h30, 8'h0C, 8'h0A}, 1'b0);
    accept_result("and");
    run_op("or", {8'hF0, 8'h0F, 8'hA0}, {8'h0C, 8'h30, 8'h05}, 3'b011, {8'hFC, 8'h3F, 8'hA5}, 1'b0);
    accept_result("or");
    run_op("not", {8'h00, 8'hFF, 8'h5A}, {8'h00, 8'h00, 8'h00}, 3'b100, {8'hFF, 8'h00, 8'hA5}, 1'b0);
    accept_result("not");
    run_op("pass0", {8'h00, 8'h00, 8'h00}, {8'h11, 8'h22, 8'h33}, 3'b110, {8'h00, 8'h00, 8'h00}, 1'b1);
    accept_result("pass0");
    run_op("add_wrap", {8'd6, 8'd10, 8'd12}, {8'd1, 8'd1, 8'd1}, 3'b000, {8'd0, 8'd0, 8'd0}, 1'b1);
    accept_result("add_wrap");

    // Test 5: flush during the operation
    op1 = {8'd5, 8'd9, 8'd12}; op2 = {8'd4, 8'd5, 8'd3}; op_sel = 3'b000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
`ifndef RNS_SCHED_PARALLEL_EN
    chk("flush_at_idx1", cur_domain, 2'd1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_result", result, 32'h0);
    chk("flush_req_ready", req_ready, 1'b1);
    seen_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) seen_valid++;
      tick();
    end
    chk("flush_no_valid", seen_valid, 0);

    // flush with req_valid in IDLE blocks the accept
    req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 1'b0);
    chk("idle_flush_ready", req_ready, 1'b1);
    tick();
    chk("idle_flush_no_valid", res_valid, 1'b0);

    // Test 6: async reset mid-RUN
    op1 = {8'd1, 8'd2, 8'd3}; op2 = {8'd1, 8'd1, 8'd1}; op_sel = 3'b000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_req_ready", req_ready, 1'b0);
    chk("arst_valid", res_valid, 1'b0);
    chk("arst_result", result, 32'h0);
    chk("arst_cd", cur_domain, 2'd0);
    chk("arst_flag", zero_eq_flag, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_op("add_after_rst", {8'd5, 8'd9, 8'd12}, {8'd4, 8'd5, 8'd3}, 3'b000, {8'd2, 8'd3, 8'd2}, 1'b0);
    accept_result("add_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
